// File: rtl/xbit_pkg.sv
// Shared types and constants for the CB-prefix (XBIT) instruction sequencer.
package xbit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch2,
    StXpt3,
    StHlRd,
    StHlOp,
    StHlWr,
    StDone
  } state_e;

  localparam logic [7:0] CB_PREFIX = 8'hCB;
  localparam logic [2:0] HL_CODE   = 3'b110;
  localparam logic [1:0] GRP_BIT   = 2'b01;

endpackage

// File: rtl/xbit_hl_rmw.sv
// (HL) read-modify-write engine: read, one ALU cycle, optional write-back.
module xbit_hl_rmw
  import xbit_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       is_bit,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic [7:0] alu_result,
  output logic       mem_rd_req,
  output logic       mem_wr_req,
  output logic [7:0] hl_operand,
  output logic       hl_alu_strobe,
  output logic [7:0] mem_wdata,
  output logic       done
);

  state_e     state_q;
  logic       rd_req_q;
  logic       wr_req_q;
  logic       strobe_q;
  logic [7:0] operand_q;
  logic [7:0] wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      strobe_q  <= 1'b0;
      operand_q <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StHlRd;
            rd_req_q <= 1'b1;
          end
        end
        StHlRd: begin
          if (mem_ack) begin
            operand_q <= mem_rdata;
            rd_req_q  <= 1'b0;
            strobe_q  <= 1'b1;
            state_q   <= StHlOp;
          end
        end
        StHlOp: begin
          strobe_q <= 1'b0;
          wdata_q  <= alu_result;
          if (is_bit) begin
            state_q <= StIdle;
          end else begin
            state_q  <= StHlWr;
            wr_req_q <= 1'b1;
          end
        end
        StHlWr: begin
          if (mem_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Combinational so the parent reaches DONE on the very next edge.
  assign done = ((state_q == StHlOp) && is_bit) || ((state_q == StHlWr) && mem_ack);

  assign mem_rd_req    = rd_req_q;
  assign mem_wr_req    = wr_req_q;
  assign hl_operand    = operand_q;
  assign hl_alu_strobe = strobe_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: rtl/xbit_prefix_sequencer.sv
// CB-prefix sequencer: second-byte fetch, XPT3 handshake with the r-operand
// decoder, (HL) read-modify-write and the CM1 restart.
module xbit_prefix_sequencer
  import xbit_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       opcode_valid,
  input  logic [7:0] opcode,
  output logic       opcode_ready,
  output logic       XBIT,
  output logic       decodedXPT3,
  output logic [7:0] Source,
  output logic [7:0] notSource,
  input  logic       reset_xpt_i,
  input  logic       set_cm1_i,
  input  logic       reset_xbit_i,
  output logic       mem_rd_req,
  output logic       mem_wr_req,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] hl_operand,
  output logic       hl_alu_strobe,
  input  logic [7:0] alu_result,
  output logic [7:0] mem_wdata,
  output logic       CM1,
  output logic       proto_err
);

  state_e     state_q;
  logic       xbit_q;
  logic       xpt3_q;
  logic       ready_q;
  logic       cm1_q;
  logic       perr_q;
  logic [7:0] source_q;
  logic [7:0] not_source_q;

  logic hl_form;
  logic bit_group;
  logic rmw_start;
  logic rmw_done;

  assign hl_form   = (source_q[2:0] == HL_CODE);
  assign bit_group = (source_q[7:6] == GRP_BIT);
  assign rmw_start = (state_q == StXpt3) && hl_form && !reset_xpt_i;

  // Outputs are set on the edge entering the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      xbit_q       <= 1'b0;
      xpt3_q       <= 1'b0;
      ready_q      <= 1'b0;
      cm1_q        <= 1'b0;
      perr_q       <= 1'b0;
      source_q     <= 8'h00;
      not_source_q <= 8'hFF;
    end else begin
      xpt3_q <= 1'b0;
      cm1_q  <= 1'b0;
      perr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (opcode_valid && (opcode == CB_PREFIX)) begin
            xbit_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StFetch2;
          end
        end
        StFetch2: begin
          if (opcode_valid) begin
            source_q     <= opcode;
            not_source_q <= ~opcode;
            ready_q      <= 1'b0;
            xpt3_q       <= 1'b1;
            state_q      <= StXpt3;
          end
        end
        StXpt3: begin
          if (!hl_form && reset_xpt_i) begin
            cm1_q   <= set_cm1_i;
            state_q <= StDone;
            if (reset_xbit_i) begin
              xbit_q <= 1'b0;
            end
          end else if (hl_form && !reset_xpt_i) begin
            state_q <= StHlRd;
          end else begin
            perr_q  <= 1'b1;
            xbit_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        // HL_OP/HL_WR are tracked inside the RMW engine; here StHlRd means "delegated".
        StHlRd: begin
          if (rmw_done) begin
            cm1_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          xbit_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  xbit_hl_rmw u_hl_rmw (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (rmw_start),
    .is_bit        (bit_group),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .alu_result    (alu_result),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .hl_operand    (hl_operand),
    .hl_alu_strobe (hl_alu_strobe),
    .mem_wdata     (mem_wdata),
    .done          (rmw_done)
  );

  assign opcode_ready = ready_q;
  assign XBIT         = xbit_q;
  assign decodedXPT3  = xpt3_q;
  assign Source       = source_q;
  assign notSource    = not_source_q;
  assign CM1          = cm1_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_xbit_prefix_sequencer.sv
// Scoreboard bench: stimulus pushes the expected CM1/proto_err response, a monitor checks it.
module tb_xbit_prefix_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       opcode_valid;
  logic [7:0] opcode;
  logic       opcode_ready;
  logic       XBIT;
  logic       decodedXPT3;
  logic [7:0] Source;
  logic [7:0] notSource;
  logic       reset_xpt_i;
  logic       set_cm1_i;
  logic       reset_xbit_i;
  logic       mem_rd_req;
  logic       mem_wr_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] hl_operand;
  logic       hl_alu_strobe;
  logic [7:0] alu_result;
  logic [7:0] mem_wdata;
  logic       CM1;
  logic       proto_err;

  xbit_prefix_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode_valid  (opcode_valid),
    .opcode        (opcode),
    .opcode_ready  (opcode_ready),
    .XBIT          (XBIT),
    .decodedXPT3   (decodedXPT3),
    .Source        (Source),
    .notSource     (notSource),
    .reset_xpt_i   (reset_xpt_i),
    .set_cm1_i     (set_cm1_i),
    .reset_xbit_i  (reset_xbit_i),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .hl_operand    (hl_operand),
    .hl_alu_strobe (hl_alu_strobe),
    .alu_result    (alu_result),
    .mem_wdata     (mem_wdata),
    .CM1           (CM1),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         proto;
    int         lat;
    logic [7:0] src;
    logic [7:0] hl;
    logic [7:0] wd;
    bit         xbit;
    int         rd;
    int         wr;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         accept_cyc = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  bit         cfg_xpt = 0;
  bit         cfg_cm1 = 0;
  bit         cfg_xbit = 0;
  int         mem_lat = 1;
  int         req_age = 0;
  logic [7:0] cfg_rd = 8'h00;
  logic [7:0] model_hl = 8'h00;
  logic [7:0] model_wd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Decoder model: answers the XPT3 pulse with the configured strobes.
  always @(negedge clk) begin
    reset_xpt_i  = decodedXPT3 & cfg_xpt;
    set_cm1_i    = decodedXPT3 & cfg_cm1;
    reset_xbit_i = decodedXPT3 & cfg_xbit;
  end

  // Memory model: acks in the mem_lat-th cycle of a request.
  always @(negedge clk) begin
    if (reset_n && (mem_rd_req || mem_wr_req)) begin
      req_age = req_age + 1;
      if (req_age == mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = cfg_rd;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
      end
    end else begin
      req_age   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (opcode_ready && opcode_valid) begin
        accept_cyc = cyc;
        rd_cnt     = 0;
        wr_cnt     = 0;
      end
      if (mem_rd_req) rd_cnt = rd_cnt + 1;
      if (mem_wr_req) wr_cnt = wr_cnt + 1;
      if (CM1 || proto_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", {30'd0, proto_err, CM1}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("kind_proto_err", {31'd0, proto_err}, {31'd0, e.proto});
          chk("kind_cm1", {31'd0, CM1}, {31'd0, !e.proto});
          chk("latency", cyc - accept_cyc, e.lat);
          chk("Source", {24'd0, Source}, {24'd0, e.src});
          chk("notSource", {24'd0, notSource}, {24'd0, ~e.src});
          chk("hl_operand", {24'd0, hl_operand}, {24'd0, e.hl});
          chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wd});
          chk("XBIT_at_end", {31'd0, XBIT}, {31'd0, e.xbit});
          chk("rd_req_cycles", rd_cnt, e.rd);
          chk("wr_req_cycles", wr_cnt, e.wr);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] b2, input logic [7:0] rd, input logic [7:0] alu,
                       input int lat_k, input bit sx, input bit sc, input bit sxb, input int gap,
                       input bit exp_proto, input int exp_lat, input bit exp_xbit);
    exp_t e;
    bit   hl;
    bit   got;
    hl = (b2[2:0] == 3'b110);
    if (!exp_proto && hl) begin
      model_hl = rd;
      model_wd = alu;
    end
    e.proto = exp_proto;
    e.lat   = exp_lat;
    e.src   = b2;
    e.hl    = model_hl;
    e.wd    = model_wd;
    e.xbit  = exp_xbit;
    e.rd    = (!exp_proto && hl) ? lat_k : 0;
    e.wr    = (!exp_proto && hl && (b2[7:6] != 2'b01)) ? lat_k : 0;
    @(posedge clk); #1;
    cfg_xpt = sx; cfg_cm1 = sc; cfg_xbit = sxb;
    cfg_rd = rd; alu_result = alu; mem_lat = lat_k;
    opcode_valid = 1'b1; opcode = 8'hCB;
    @(posedge clk); #1;
    opcode_valid = 1'b0; opcode = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    opcode_valid = 1'b1; opcode = b2;
    sb.push_back(e);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (opcode_ready) begin
        got = 1;
        break;
      end
    end
    chk("byte2_accepted", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    opcode_valid = 1'b0; opcode = 8'h00;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("response_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bit got;
    reset_n = 1'b0; opcode_valid = 1'b0; opcode = 8'h00; alu_result = 8'h00;
    reset_xpt_i = 1'b0; set_cm1_i = 1'b0; reset_xbit_i = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_XBIT", {31'd0, XBIT}, 32'd0);
    chk("rst_opcode_ready", {31'd0, opcode_ready}, 32'd0);
    chk("rst_Source", {24'd0, Source}, 32'h00);
    chk("rst_notSource", {24'd0, notSource}, 32'hFF);
    chk("rst_CM1", {31'd0, CM1}, 32'd0);
    chk("rst_mem_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // RLC B, SET 3,(HL), BIT 7,(HL), SRL (HL) with 2 wait states and a fetch gap
    issue(8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 2, 0);
    issue(8'hDE, 8'h00, 8'h08, 1, 0, 0, 0, 0, 0, 5, 1);
    issue(8'h7E, 8'h80, 8'h5A, 1, 0, 0, 0, 0, 0, 4, 1);
    issue(8'h3E, 8'h81, 8'h40, 3, 0, 0, 0, 2, 0, 9, 1);
    // (HL) byte with reset_xpt_i, then register byte without it
    issue(8'h06, 8'h00, 8'h00, 1, 1, 1, 1, 0, 1, 2, 0);
    issue(8'h47, 8'h00, 8'h00, 1, 0, 1, 1, 0, 1, 2, 0);
    chk("idle_XBIT_after_err", {31'd0, XBIT}, 32'd0);

    // Reset while HL_RD waits for an ack that never comes
    @(posedge clk); #1;
    cfg_xpt = 0; cfg_cm1 = 0; cfg_xbit = 0; mem_lat = 1000;
    opcode_valid = 1'b1; opcode = 8'hCB;
    @(posedge clk); #1;
    opcode = 8'h46;
    @(posedge clk); #1;
    opcode_valid = 1'b0; opcode = 8'h00;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_req) begin
        got = 1;
        break;
      end
    end
    chk("rd_req_before_reset", {31'd0, got}, 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("midrst_XBIT", {31'd0, XBIT}, 32'd0);
    chk("midrst_Source", {24'd0, Source}, 32'h00);
    chk("midrst_notSource", {24'd0, notSource}, 32'hFF);
    chk("midrst_hl_operand", {24'd0, hl_operand}, 32'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_hl = 8'h00;
    model_wd = 8'h00;
    issue(8'h19, 8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 2, 0);

    chk("final_XBIT", {31'd0, XBIT}, 32'd0);
    chk("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xbit_prefix_sequencer.md
# xbit_prefix_sequencer

Sequencer for the CB-prefix (XBIT) instruction group: RLC/RL/RRC/RR/SLA/SRA/SRL r/(HL) and BIT/SET/RES b,r/(HL). It detects the CB prefix on the M1 fetch stream and fetches the second opcode byte. It drives the XPT3 decode phase and the latched `Source`/`notSource` into the XBIT r-operand decoder, then takes that decoder's completion strobes back. It runs the (HL) memory read-modify-write path, which the r-operand decoder does not handle, and it issues the CM1 restart toward the main fetch controller.

## Interface
- No parameters; opcode width fixed at 8.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode_valid` in 1: fetch bus holds a valid opcode byte.
- `opcode` in 8: fetched byte.
- `opcode_ready` out 1: block consumes the byte this cycle.
- `XBIT` out 1: CB-prefix instruction in progress.
- `decodedXPT3` out 1: XPT3 decode phase, one-cycle pulse.
- `Source` out 8: latched second opcode byte.
- `notSource` out 8: bitwise complement of `Source`, registered.
- `reset_xpt_i` in 1: decoder completion strobe, register form.
- `set_cm1_i` in 1: decoder request for CM1, register form.
- `reset_xbit_i` in 1: decoder request to clear XBIT.
- `mem_rd_req` out 1: (HL) read request, level.
- `mem_wr_req` out 1: (HL) write request, level.
- `mem_ack` in 1: memory access complete, one cycle.
- `mem_rdata` in 8: read data, valid with `mem_ack`.
- `hl_operand` out 8: latched (HL) byte, fed to the ALU.
- `hl_alu_strobe` out 1: ALU evaluates `hl_operand` this cycle.
- `alu_result` in 8: ALU result, valid during `hl_alu_strobe`.
- `mem_wdata` out 8: latched `alu_result`.
- `CM1` out 1: one-cycle pulse; start the next M1 fetch.
- `proto_err` out 1: one-cycle pulse; decoder/sequencer disagreement.

## Operation
- States: IDLE, FETCH2, XPT3, HL_RD, HL_OP, HL_WR, DONE.
- Reset values:
  - State is IDLE.
  - `XBIT`, `decodedXPT3`, `opcode_ready`, `mem_rd_req`, `mem_wr_req`, `hl_alu_strobe`, `CM1`, `proto_err` are 0.
  - `Source` = 8'h00, `notSource` = 8'hFF.
  - `hl_operand` = 8'h00, `mem_wdata` = 8'h00.
- IDLE:
  - The block observes the fetch stream passively; `opcode_ready` stays 0.
  - `opcode_valid && opcode == 8'hCB` sets `XBIT` and moves to FETCH2.
  - The main controller consumes the CB byte itself.
- FETCH2:
  - `opcode_ready` = 1.
  - On `opcode_valid`, load `Source` <= `opcode` and `notSource` <= `~opcode`, then go to XPT3.
- XPT3 (exactly one cycle):
  - `decodedXPT3` = 1.
  - Register form (`Source[2:0] != 3'b110`) requires `reset_xpt_i` this cycle:
    - Next state is DONE.
    - `reset_xbit_i` clears `XBIT` at the edge.
    - `set_cm1_i` causes the `CM1` pulse in DONE.
  - (HL) form (`Source[2:0] == 3'b110`) requires `reset_xpt_i` = 0; next state is HL_RD.
  - Mismatch in either direction: pulse `proto_err`, clear `XBIT`, go to IDLE, no `CM1`.
- HL_RD:
  - Hold `mem_rd_req` until `mem_ack`.
  - On `mem_ack`, `hl_operand` <= `mem_rdata`, then go to HL_OP.
- HL_OP (one cycle):
  - `hl_alu_strobe` = 1 and `mem_wdata` <= `alu_result`.
  - BIT group (`Source[7:6] == 2'b01`) goes to DONE; no write.
  - Otherwise go to HL_WR.
- HL_WR: hold `mem_wr_req` until `mem_ack`, then go to DONE.
- DONE: `CM1` = 1 for one cycle, `XBIT` cleared, then IDLE.
- `Source`/`notSource` hold their value from the FETCH2 load until the next FETCH2 load.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Register form: byte accepted at edge N, XPT3 in cycle N+1, DONE/`CM1` in cycle N+2, IDLE in cycle N+3.
- (HL) form, zero-wait memory (ack in the first request cycle):
  - SET/RES/shift: `CM1` 5 cycles after the byte is accepted (XPT3, HL_RD, HL_OP, HL_WR, DONE).
  - BIT: `CM1` 4 cycles after the byte is accepted.
- `mem_ack` outside HL_RD/HL_WR is ignored.
- A request never drops before its ack.
- `opcode_valid` low in FETCH2 means wait, unbounded.
- Decoder strobes outside XPT3 are ignored.
- A CB byte seen in IDLE in the same cycle as DONE's return is not possible: DONE always spends one cycle before IDLE.
- Asynchronous reset in any state, including mid memory request:
  - Immediate IDLE; all outputs go to their reset values.
  - Requests drop without waiting for ack.

## Structure
- Shared package `xbit_pkg`:
  - State enum.
  - `CB_PREFIX` = 8'hCB.
  - `HL_CODE` = 3'b110.
  - `GRP_BIT` = 2'b01.
- One sub-module: `xbit_hl_rmw`, covering HL_RD/HL_OP/HL_WR and the `hl_operand`/`mem_wdata` latches, started from XPT3 and returning a done pulse.

## Test plan
- `RLC B`: CB then 8'h00 with `reset_xpt_i`/`set_cm1_i`/`reset_xbit_i` pulsed in XPT3 -> `Source` = 8'h00, `notSource` = 8'hFF, `CM1` 2 cycles after accept, `XBIT` low.
- `SET 3,(HL)`: CB, 8'hDE, `mem_rdata` = 8'h00, `alu_result` = 8'h08, zero-wait -> `hl_operand` = 8'h00, write with `mem_wdata` = 8'h08, `CM1` 5 cycles after accept.
- `BIT 7,(HL)`: CB, 8'h7E, `mem_rdata` = 8'h80 -> one read, `mem_wr_req` never asserted, `CM1` 4 cycles after accept.
- Wait states: `SRL (HL)` (8'h3E) with `mem_ack` delayed 3 cycles on both read and write -> requests held steady, `CM1` 9 cycles after accept.
- Protocol error: `LD`-style mismatch, 8'h06 with `reset_xpt_i` = 1 -> `proto_err` pulse, no `CM1`, `XBIT` = 0, state IDLE.
- Reset mid-HL_RD, then `RR C` (8'h19) with decoder strobes pulsed -> outputs reset immediately; the new instruction completes normally.
